// File: rtl/adc_readout_accumulator.sv
// Per-lane popcount accumulation of ADC thermometer codes over a programmed sample
// count, followed by packing of the per-lane sums into output FIFO words.
module adc_readout_accumulator #(
  parameter int NUM_ADC         = 32,
  parameter int ADC_WIDTH_THERM = 15,
  parameter int ADC_WIDTH       = 4,
  parameter int PHD_ACC_WIDTH   = 16,
  parameter int DATAOUT_WIDTH   = 64
) (
  input  logic                               CLK,
  input  logic                               reset,
  input  logic                               start,
  input  logic [7:0]                         num_samples,
  input  logic                               adc_valid,
  input  logic [NUM_ADC*ADC_WIDTH_THERM-1:0] ADCOUT_THERM,
  output logic                               busy,
  output logic                               done,
  output logic                               bubble_err,
  output logic                               overrun_err,
  output logic                               push_n_oFIFO_ext,
  input  logic                               full_oFIFO_ext,
  output logic [DATAOUT_WIDTH-1:0]           din_oFIFO_ext
);

  localparam int ACC_PER_WORD = DATAOUT_WIDTH / PHD_ACC_WIDTH;
  localparam int NUM_WORDS    = NUM_ADC * PHD_ACC_WIDTH / DATAOUT_WIDTH;
  localparam int IDX_W        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LANE_W       = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [8:0]               count;
  logic [8:0]               target;
  logic [IDX_W-1:0]         index;
  logic                     push;
  logic                     last_sample;
  logic                     any_bubble;
  logic [ADC_WIDTH-1:0]     sample [NUM_ADC];
  logic [PHD_ACC_WIDTH-1:0] acc    [NUM_ADC];

  function automatic logic [ADC_WIDTH-1:0] therm_to_count(
    input logic [ADC_WIDTH_THERM-1:0] code
  );
    logic [ADC_WIDTH-1:0] cnt;
    cnt = '0;
    for (int b = 0; b < ADC_WIDTH_THERM; b++) begin
      cnt = cnt + ADC_WIDTH'(code[b]);
    end
    return cnt;
  endfunction

  // A legal code is 2^k-1: adding one clears every set bit.
  function automatic logic therm_is_bubbled(
    input logic [ADC_WIDTH_THERM-1:0] code
  );
    logic [ADC_WIDTH_THERM-1:0] nxt;
    nxt = code + 1'b1;
    return (code & nxt) != '0;
  endfunction

  function automatic logic [PHD_ACC_WIDTH-1:0] sat_add(
    input logic [PHD_ACC_WIDTH-1:0] a,
    input logic [ADC_WIDTH-1:0]     v
  );
    logic [PHD_ACC_WIDTH:0] sum;
    sum = {1'b0, a} + (PHD_ACC_WIDTH + 1)'(v);
    return sum[PHD_ACC_WIDTH] ? '1 : sum[PHD_ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    any_bubble = 1'b0;
    for (int i = 0; i < NUM_ADC; i++) begin
      sample[i]  = therm_to_count(ADCOUT_THERM[i*ADC_WIDTH_THERM +: ADC_WIDTH_THERM]);
      any_bubble = any_bubble | therm_is_bubbled(ADCOUT_THERM[i*ADC_WIDTH_THERM +: ADC_WIDTH_THERM]);
    end
  end

  assign last_sample = adc_valid && ((count + 9'd1) == target);

  always_comb begin
    next_state = state;
    push       = 1'b0;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (last_sample) next_state = DRAIN;
      DRAIN: begin
        push = !full_oFIFO_ext;
        if (push && (index == LAST_IDX)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign push_n_oFIFO_ext = !push;
  assign busy             = (state == ACCUM) || (state == DRAIN);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      target      <= '0;
      index       <= '0;
      done        <= 1'b0;
      bubble_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == DRAIN) && push && (index == LAST_IDX);
      case (state)
        IDLE: begin
          if (start) begin
            count       <= '0;
            target      <= (num_samples == 8'd0) ? 9'd256 : {1'b0, num_samples};
            index       <= '0;
            bubble_err  <= 1'b0;
            overrun_err <= 1'b0;
          end
        end
        ACCUM: begin
          if (adc_valid) begin
            count <= count + 9'd1;
            if (any_bubble) bubble_err <= 1'b1;
            if (last_sample) index <= '0;
          end
        end
        DRAIN: begin
          if (push) index <= (index == LAST_IDX) ? '0 : index + 1'b1;
          // Late samples are dropped but still screened for bubbles.
          if (adc_valid) begin
            overrun_err <= 1'b1;
            if (any_bubble) bubble_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ADC; i++) acc[i] <= '0;
    end else if ((state == IDLE) && start) begin
      for (int i = 0; i < NUM_ADC; i++) acc[i] <= '0;
    end else if ((state == ACCUM) && adc_valid) begin
      for (int i = 0; i < NUM_ADC; i++) acc[i] <= sat_add(acc[i], sample[i]);
    end
  end

  always_comb begin
    din_oFIFO_ext = '0;
    for (int j = 0; j < ACC_PER_WORD; j++) begin
      din_oFIFO_ext[j*PHD_ACC_WIDTH +: PHD_ACC_WIDTH] =
        acc[LANE_W'(int'(index) * ACC_PER_WORD + j)];
    end
  end

endmodule

// File: tb/tb_adc_readout_accumulator.sv
// Randomized scoreboard bench for adc_readout_accumulator: a per-lane sum model
// queues expected FIFO words; a negedge monitor pops and compares on each push.
module tb_adc_readout_accumulator;
  localparam int NA = 32;
  localparam int TW = 15;
  localparam int NW = 8;

  logic           CLK = 1'b0;
  logic           reset;
  logic           start;
  logic [7:0]     num_samples;
  logic           adc_valid;
  logic [NA*TW-1:0] ADCOUT_THERM;
  logic           busy, done, bubble_err, overrun_err, push_n_oFIFO_ext;
  logic           full_oFIFO_ext;
  logic [63:0]    din_oFIFO_ext;

  always #5 CLK = ~CLK;

  adc_readout_accumulator dut (
    .CLK(CLK), .reset(reset), .start(start), .num_samples(num_samples),
    .adc_valid(adc_valid), .ADCOUT_THERM(ADCOUT_THERM), .busy(busy), .done(done),
    .bubble_err(bubble_err), .overrun_err(overrun_err),
    .push_n_oFIFO_ext(push_n_oFIFO_ext), .full_oFIFO_ext(full_oFIFO_ext),
    .din_oFIFO_ext(din_oFIFO_ext)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          pushes = 0;
  bit          expect_done = 0;
  int          sums[NA];
  bit          bub_exp, ovr_exp;
  logic [14:0] codes[NA];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_therm(input logic [14:0] c);
    for (int k = 0; k <= 15; k++) if (c == 15'((1 << k) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gen_codes(input int mode);
    for (int i = 0; i < NA; i++) begin
      case (mode)
        0: codes[i] = 15'h007F;
        1: codes[i] = 15'((1 << (i % 16)) - 1);
        2: codes[i] = 15'h7FFF;
        default: codes[i] = ($urandom_range(0, 7) == 0) ? 15'($urandom)
                                                        : 15'((1 << $urandom_range(0, 15)) - 1);
      endcase
    end
  endtask

  // where: 0 = ignored (IDLE), 1 = accumulated, 2 = late sample in drain
  task automatic drive_sample(input int where);
    for (int i = 0; i < NA; i++) begin
      ADCOUT_THERM[i*TW +: TW] = codes[i];
      if (where == 1) begin
        sums[i] = sums[i] + $countones(codes[i]);
        if (sums[i] > 65535) sums[i] = 65535;
      end
      if (where != 0 && !is_therm(codes[i])) bub_exp = 1'b1;
    end
    if (where == 2) ovr_exp = 1'b1;
    adc_valid = 1'b1;
  endtask

  task automatic push_expected();
    logic [63:0] w;
    for (int k = 0; k < NW; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'(sums[4*k + j]);
      sb.push_back('{data: w, last: (k == NW - 1)});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push_n"}, 64'(push_n_oFIFO_ext), 64'd1);
    check({tag, "_din"}, din_oFIFO_ext, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_bubble"}, 64'(bubble_err), 64'd0);
    check({tag, "_overrun"}, 64'(overrun_err), 64'd0);
  endtask

  // full_mode: 0 never full, 1 full 3 cycles then toggling, 2 random
  task automatic run_meas(input int n8, input int mode, input int full_mode,
                          input bit overrun, input bit ign_start, input int reset_after);
    int nsamp, cyc, base;
    bit was_reset;
    nsamp = (n8 == 0) ? 256 : n8;
    for (int i = 0; i < NA; i++) sums[i] = 0;
    bub_exp = 1'b0;
    ovr_exp = 1'b0;
    was_reset = 1'b0;
    start = 1'b1;
    num_samples = 8'(n8);
    gen_codes(3);
    drive_sample(0);
    tick();
    start = 1'b0;
    adc_valid = 1'b0;
    for (int s = 0; s < nsamp; s++) begin
      gen_codes(mode);
      drive_sample(1);
      if (s == nsamp - 1) push_expected();
      tick();
      adc_valid = 1'b0;
      if (ign_start && s == nsamp / 2 && s < nsamp - 1) begin
        start = 1'b1;
        num_samples = 8'd1;
        tick();
        start = 1'b0;
        num_samples = 8'(n8);
      end
    end
    if (overrun) begin
      gen_codes(2);
      codes[5] = 15'h0005;
      drive_sample(2);
    end
    base = pushes;
    cyc = 0;
    while (sb.size() > 0 && cyc < 300) begin
      case (full_mode)
        1: full_oFIFO_ext = (cyc < 3) ? 1'b1 : 1'(cyc % 2);
        2: full_oFIFO_ext = ($urandom_range(0, 3) == 0);
        default: full_oFIFO_ext = 1'b0;
      endcase
      if (reset_after >= 0 && pushes >= base + reset_after) begin
        full_oFIFO_ext = 1'b1;
        reset = 1'b0;
        sb.delete();
        tick();
        full_oFIFO_ext = 1'b0;
        check_reset_outputs("mid_drain_reset");
        reset = 1'b1;
        repeat (12) tick();
        check("no_push_after_reset", 64'(pushes), 64'(base + reset_after));
        was_reset = 1'b1;
        break;
      end
      tick();
      adc_valid = 1'b0;
      cyc++;
    end
    full_oFIFO_ext = 1'b0;
    adc_valid = 1'b0;
    if (!was_reset) begin
      check("drain_words_left", 64'(sb.size()), 64'd0);
      tick();
      tick();
      check("bubble_err", 64'(bubble_err), 64'(bub_exp));
      check("overrun_err", 64'(overrun_err), 64'(ovr_exp));
      check("busy_after_drain", 64'(busy), 64'd0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (expect_done) begin
        check("done_pulse", 64'(done), 64'd1);
        expect_done = 1'b0;
      end else if (done === 1'b1) begin
        check("unexpected_done", 64'(done), 64'd0);
      end
      if (full_oFIFO_ext === 1'b1 && reset === 1'b1)
        check("push_n_while_full", 64'(push_n_oFIFO_ext), 64'd1);
      if (push_n_oFIFO_ext === 1'b0) begin
        pushes++;
        if (sb.size() == 0) begin
          check("unexpected_push", 64'(push_n_oFIFO_ext), 64'd1);
        end else begin
          e = sb.pop_front();
          check("din_word", din_oFIFO_ext, e.data);
          if (e.last) expect_done = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset = 1'b0;
    start = 1'b0;
    num_samples = 8'd0;
    adc_valid = 1'b0;
    ADCOUT_THERM = '0;
    full_oFIFO_ext = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    reset = 1'b1;
    tick();
    run_meas(4, 0, 0, 1'b0, 1'b0, -1);
    run_meas(1, 1, 0, 1'b0, 1'b0, -1);
    run_meas(3, 3, 1, 1'b0, 1'b0, -1);
    run_meas(0, 2, 0, 1'b1, 1'b0, -1);
    run_meas(5, 3, 2, 1'b0, 1'b1, -1);
    run_meas(2, 3, 0, 1'b0, 1'b0, 3);
    for (int r = 0; r < 4; r++) run_meas($urandom_range(1, 6), 3, 2, 1'($urandom_range(0, 1)), 1'b0, -1);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_readout_accumulator.md
# adc_readout_accumulator

Downstream consumer of the crossbar core's ADC thermometer outputs. Converts each 15-bit ADC thermometer code to a 4-bit count and accumulates it per ADC over a programmed number of samples. Packs the per-ADC sums into 64-bit words and pushes them into the external output data FIFO using the push_n/full handshake.

## Interface
Parameters:
- NUM_ADC, 32, number of ADC lanes
- ADC_WIDTH_THERM, 15, thermometer code width per ADC
- ADC_WIDTH, 4, binary width of one converted sample
- PHD_ACC_WIDTH, 16, per-ADC accumulator width
- DATAOUT_WIDTH, 64, output FIFO word width; must be a multiple of PHD_ACC_WIDTH

Ports:
- CLK  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a measurement; honoured only in IDLE
- num_samples  in  8  samples to accumulate; latched on start; 0 means 256
- adc_valid  in  1  strobe; ADCOUT_THERM is valid this cycle
- ADCOUT_THERM  in  NUM_ADC*ADC_WIDTH_THERM  lane i occupies bits [15i+14:15i]
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse after the last word is pushed
- bubble_err  out  1  sticky: a thermometer code that was not contiguous-from-LSB was seen
- overrun_err  out  1  sticky: adc_valid arrived in DRAIN
- push_n_oFIFO_ext  out  1  active-low push to the output FIFO
- full_oFIFO_ext  in  1  output FIFO full
- din_oFIFO_ext  out  DATAOUT_WIDTH  push data

## Operation
- Conversion: sample value = popcount of the lane's 15 bits (0..15).
  - This is bubble tolerant.
  - bubble_err sets when a code ≠ (2^k − 1) for every k in 0..15.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - On start: clear all NUM_ADC accumulators, the sample counter, bubble_err and overrun_err.
  - Latch num_samples, then go to ACCUM.
  - adc_valid is ignored in IDLE.
- ACCUM:
  - Each adc_valid adds every lane's value into its accumulator and increments the counter.
  - Accumulators saturate at 2^PHD_ACC_WIDTH − 1; this is unreachable with the defaults, where the maximum is 256·15 = 3840.
  - The adc_valid that makes the count equal N (the latched value, with 0 meaning 256) is accumulated, and the next state is DRAIN with word index 0.
- DRAIN:
  - W = NUM_ADC·PHD_ACC_WIDTH/DATAOUT_WIDTH words; the default is 8.
  - Word k bits [16j+15:16j] = acc[4k+j] for j = 0..3, zero-extended.
  - push_n_oFIFO_ext = !(state==DRAIN && !full_oFIFO_ext). This is combinational from registered state and full.
  - din_oFIFO_ext = word[index]. It holds while full is high.
  - On a push, the index increments. After the push of word W−1: go to IDLE and pulse done for the next cycle.
  - adc_valid in DRAIN sets overrun_err; the sample is discarded.
- start while busy is ignored. Accumulators and the current word are unaffected.
- Simultaneous start and adc_valid in IDLE: start is taken; that sample is not accumulated.

## Timing
Reset values (reset low at a clock edge):
- state = IDLE, push_n_oFIFO_ext = 1, din_oFIFO_ext = 0, busy = 0, done = 0, bubble_err = 0, overrun_err = 0.
- Accumulators, counter and index = 0.
- Reset mid-ACCUM or mid-DRAIN aborts immediately. No further pushes occur.

Latency and throughput:
- start at edge t → busy is high from cycle t+1. The first adc_valid can be accepted at edge t+1.
- Final adc_valid sampled at edge t → DRAIN in cycle t+1. If full is low, word 0 is presented with push_n low in cycle t+1 and captured by the FIFO at edge t+2.
- With full low throughout: W consecutive pushes in cycles t+1..t+W, state is IDLE in cycle t+W+1, and done is high during cycle t+W+1 only.
- Each cycle with full high during DRAIN inserts one stall cycle. There is no data loss and no duplicate push.
- bubble_err and overrun_err update one cycle after the offending adc_valid. They hold until the next accepted start or reset.

## Test plan
- Basic:
  - Stimulus: num_samples=4; four adc_valid with every lane = 0x007F (value 7).
  - Response: 8 pushes, each word 0x001C_001C_001C_001C. done pulses once. bubble_err stays 0.
- Packing:
  - Stimulus: N=1; lane i code = 2^(i mod 16) − 1.
  - Response: word 0 = {16'd3, 16'd2, 16'd1, 16'd0}; word 3 = {16'd15, 16'd14, 16'd13, 16'd12}.
- Backpressure:
  - Stimulus: full_oFIFO_ext high for 3 cycles at DRAIN entry, then toggling.
  - Response: push_n stays high while full is high; din is stable; exactly 8 pushes in order.
- Max count and error flags:
  - Stimulus: num_samples=0 with all lanes 0x7FFF; 256 adc_valid; one extra adc_valid in DRAIN; one lane driven with code 0x0005.
  - Response: every sum = 3840 (0x0F00). overrun_err = 1. bubble_err = 1.
- Reset and ignored start:
  - Stimulus: reset low during DRAIN after 3 pushes; later, start re-asserted during ACCUM.
  - Response: after reset, push_n = 1 with no further pushes and all outputs at reset values. The mid-ACCUM start is ignored and the sums are unchanged.
